// File: rtl/first_pack.sv
// Shared FIFO-side definitions: data geometry of the synchronous FIFO and the
// state encoding of the stream reader that drains it.
package first_pack;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    RDR_IDLE,
    RDR_RUN,
    RDR_DRAIN
  } rdr_state_e;

endpackage

// File: rtl/fifo_rdr_skid.sv
// Two-entry output buffer for the FIFO stream reader. The head word is always
// in e0; a push during a pop refills the slot that the pop frees.
module fifo_rdr_skid
  import first_pack::*;
#(
  parameter int DATA_W = FIFO_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else             e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // occ stays the same: the incoming word lands behind whatever remains
          if (occ == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = e0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the synchronous FIFO onto a valid/ready stream with burst framing.
// Optional underflow checking is enabled with macro RDR_UFLOW_CHK_EN.
module fifo_stream_reader
  import first_pack::*;
#(
  parameter int DATA_W    = FIFO_WIDTH,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_underflow,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              err_underflow
);

  localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);

  rdr_state_e      state;
  logic            pending;
  logic [1:0]      occ;
  logic [BC_W-1:0] burst_cnt;
  logic            pop;
  logic            push;
  logic [2:0]      inflight;

  assign pop      = m_valid & m_ready;
  assign inflight = {1'b0, occ} + {2'b00, pending};
  // Credit counts the slot freed by this cycle's pop, so the m_ready path is combinational.
  assign fifo_rd_en = (state == RDR_RUN) & ~fifo_empty & (inflight <= ({2'b00, pop} + 3'd1));

`ifdef RDR_UFLOW_CHK_EN
  assign push = pending & ~fifo_underflow;
`ifndef SYNTHESIS
  a_no_uflow: assert property (@(posedge clk) disable iff (!rst_n) !(pending && fifo_underflow))
    else $warning("read refused by FIFO, word dropped");
`endif
`else
  logic uflow_unused;
  assign push         = pending;
  assign uflow_unused = fifo_underflow;
`endif

  fifo_rdr_skid #(.DATA_W(DATA_W)) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (fifo_data_out),
    .dout (m_data),
    .occ  (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RDR_IDLE;
      pending       <= 1'b0;
      burst_cnt     <= '0;
      beat_cnt      <= '0;
      err_underflow <= 1'b0;
    end else begin
      pending <= fifo_rd_en;
      if (pop) begin
        beat_cnt  <= beat_cnt + CNT_W'(1);
        burst_cnt <= (burst_cnt == BC_LAST) ? '0 : burst_cnt + BC_W'(1);
      end
`ifdef RDR_UFLOW_CHK_EN
      if (pending && fifo_underflow) err_underflow <= 1'b1;
`endif
      unique case (state)
        RDR_IDLE:  if (en) state <= RDR_RUN;
        RDR_RUN:   if (!en) state <= RDR_DRAIN;
        RDR_DRAIN: begin
          if (en) begin
            state <= RDR_RUN;
          end else if (!pending && occ == 2'd0) begin
            state     <= RDR_IDLE;
            burst_cnt <= '0;
          end
        end
        default: state <= RDR_IDLE;
      endcase
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid & (burst_cnt == BC_LAST);
  assign busy    = (state != RDR_IDLE) | (occ != 2'd0) | pending;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural FIFO with
// registered read data and registered underflow.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data_out;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic [15:0] beat_cnt;
  logic        err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fuf;
  logic        force_uf = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_underflow = fuf | force_uf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= wr_ptr;
      fifo_data_out <= '0;
      fuf           <= 1'b0;
    end else begin
      fuf <= 1'b0;
      if (fifo_rd_en) begin
        if (!fifo_empty) begin
          fifo_data_out <= mem[rd_ptr % 256];
          rd_ptr        <= rd_ptr + 1;
        end else begin
          fuf <= 1'b1;
        end
      end
    end
  end

  fifo_stream_reader #(.DATA_W(16), .BURST_LEN(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy),
    .beat_cnt      (beat_cnt),
    .err_underflow (err_underflow)
  );

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; force_uf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({m_valid, m_last, busy, fifo_rd_en, err_underflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {m_valid, m_last, busy, fifo_rd_en, err_underflow});
    end
    n_checks++;
    if (m_data !== 16'h0 || beat_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: m_data=%h beat_cnt=%0d want 0/0", m_data, beat_cnt);
    end
  endtask

  task automatic test_stream();
    int rd_bad = 0;
    logic exp_v;
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    en = 1'b1; m_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      if (fifo_rd_en && fifo_empty) rd_bad++;
      exp_v = (c >= 3 && c <= 10);
      n_checks++;
      if (m_valid !== exp_v) begin
        n_fail++;
        $display("FAIL stream_valid c=%0d: got %b want %b", c, m_valid, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (m_data !== 16'(c - 2) || m_last !== ((c - 2) % 4 == 0)) begin
          n_fail++;
          $display("FAIL stream_beat c=%0d: data=%h last=%b want %h/%b", c, m_data, m_last,
                   16'(c - 2), ((c - 2) % 4 == 0));
        end
      end
    end
    n_checks++;
    if (beat_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL stream_beat_cnt: got %0d want 8", beat_cnt);
    end
    n_checks++;
    if (rd_bad !== 0) begin
      n_fail++;
      $display("FAIL stream_rd_on_empty: got %0d want 0", rd_bad);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) push_word(16'h0050 + 16'(i));
    m_ready = 1'b0;
    for (int c = 0; c < 6; c++) @(negedge clk);
    #1;
    n_checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || beat_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL midreset_pre: valid=%b busy=%b beat_cnt=%0d want 1/1/8", m_valid, busy, beat_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_last, busy, fifo_rd_en} !== 4'b0 || m_data !== 16'h0 || beat_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset: flags=%b data=%h beat_cnt=%0d want 0000/0000/0",
               {m_valid, m_last, busy, fifo_rd_en}, m_data, beat_cnt);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_backpressure();
    int idx = 0, rd_bad = 0, acc = 0, over = 0;
    logic stalled = 1'b0;
    logic [15:0] pdata = '0;
    logic plast = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'h0100 + 16'(i));
    en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      m_ready = (c % 2 == 1);
      #1;
      if (fifo_rd_en && fifo_empty) rd_bad++;
      if (stalled) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== pdata || m_last !== plast) begin
          n_fail++;
          $display("FAIL bp_hold c=%0d: v=%b data=%h last=%b want 1/%h/%b", c, m_valid, m_data, m_last, pdata, plast);
        end
      end
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0100 + 16'(idx + 1) || m_last !== (idx % 4 == 3)) begin
          n_fail++;
          $display("FAIL bp_beat %0d: data=%h last=%b want %h/%b", idx, m_data, m_last,
                   16'h0100 + 16'(idx + 1), (idx % 4 == 3));
        end
        idx++;
      end
      if (fifo_rd_en && !fifo_empty) acc++;
      if (acc - idx > 2) over++;
      stalled = m_valid & ~m_ready;
      pdata = m_data;
      plast = m_last;
    end
    n_checks++;
    if (idx !== 8 || beat_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL bp_count: beats=%0d beat_cnt=%0d want 8/8", idx, beat_cnt);
    end
    n_checks++;
    if (rd_bad !== 0 || over !== 0) begin
      n_fail++;
      $display("FAIL bp_credit: rd_on_empty=%0d overcommit=%0d want 0/0", rd_bad, over);
    end
  endtask

  task automatic test_drain();
    int rds = 0, idx = 0;
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'h0200 + 16'(i));
    en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      if (fifo_rd_en) rds++;
    end
    n_checks++;
    if (rds !== 2 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_fill: reads=%0d valid=%b want 2/1", rds, m_valid);
    end
    en = 1'b0;
    rds = 0;
    @(negedge clk);
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (fifo_rd_en) rds++;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0200 + 16'(idx + 1)) begin
          n_fail++;
          $display("FAIL drain_beat %0d: got %h want %h", idx, m_data, 16'h0200 + 16'(idx + 1));
        end
        idx++;
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (rds !== 0 || idx !== 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_done: reads=%0d beats=%0d busy=%b want 0/2/0", rds, idx, busy);
    end
    en = 1'b1;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0203 + 16'(idx) || m_last !== (idx == 3)) begin
          n_fail++;
          $display("FAIL drain_rerun %0d: data=%h last=%b want %h/%b", idx, m_data, m_last,
                   16'h0203 + 16'(idx), (idx == 3));
        end
        idx++;
      end
    end
    n_checks++;
    if (idx !== 6) begin
      n_fail++;
      $display("FAIL drain_rerun_count: got %0d want 6", idx);
    end
  endtask

  task automatic test_empty_gap();
    int idx = 0, gap = 0;
    do_reset();
    for (int i = 1; i <= 3; i++) push_word(16'h0010 + 16'(i));
    en = 1'b1; m_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 9) for (int i = 4; i <= 8; i++) push_word(16'h0010 + 16'(i));
      #1;
      if (!m_valid && idx == 3) gap++;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'h0010 + 16'(idx + 1) || m_last !== (idx % 4 == 3)) begin
          n_fail++;
          $display("FAIL gap_beat %0d: data=%h last=%b want %h/%b", idx, m_data, m_last,
                   16'h0010 + 16'(idx + 1), (idx % 4 == 3));
        end
        idx++;
      end
    end
    n_checks++;
    if (idx !== 8 || gap !== 5) begin
      n_fail++;
      $display("FAIL gap_summary: beats=%0d gap=%0d want 8/5", idx, gap);
    end
  endtask

  task automatic test_underflow();
    int idx = 0;
    logic [15:0] first = '0;
    do_reset();
    push_word(16'h00A1);
    push_word(16'h00A2);
    en = 1'b1; m_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      force_uf = (c == 2);
      #1;
      if (m_valid && m_ready) begin
        if (idx == 0) first = m_data;
        idx++;
      end
    end
`ifdef RDR_UFLOW_CHK_EN
    n_checks++;
    if (idx !== 1 || first !== 16'h00A2 || err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uflow_drop: beats=%0d first=%h err=%b want 1/00a2/1", idx, first, err_underflow);
    end
`else
    n_checks++;
    if (idx !== 2 || first !== 16'h00A1 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_keep: beats=%0d first=%h err=%b want 2/00a1/0", idx, first, err_underflow);
    end
`endif
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
`ifdef RDR_UFLOW_CHK_EN
    if (err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uflow_sticky: got %b want 1", err_underflow);
    end
`else
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_tied: got %b want 0", err_underflow);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reset_midstream();
    test_backpressure();
    test_drain();
    test_empty_gap();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
